// File: rtl/llki_pkg.sv
// rtl/llki_pkg.sv - host index type, order-FIFO depth default and round-robin pick
package llki_pkg;
    typedef enum logic {
        HOST0 = 1'b0,
        HOST1 = 1'b1
    } host_e;

    localparam int unsigned DEPTH_DEFAULT = 4;

    // On a tie the host that was not granted last wins.
    function automatic host_e rr_pick(input logic req0, input logic req1, input host_e last);
        if (req0 && req1) return (last == HOST0) ? HOST1 : HOST0;
        return req1 ? HOST1 : HOST0;
    endfunction
endpackage

// File: rtl/tlul_pkg.sv
// rtl/tlul_pkg.sv - TileLink-UL host-to-device and device-to-host channel structs
package tlul_pkg;
    typedef struct packed {
        logic                        a_valid;
        logic [2:0]                  a_opcode;
        logic [top_pkg::TL_SZW-1:0]  a_size;
        logic [top_pkg::TL_AIW-1:0]  a_source;
        logic [top_pkg::TL_AW-1:0]   a_address;
        logic [top_pkg::TL_DBW-1:0]  a_mask;
        logic [top_pkg::TL_DW-1:0]   a_data;
        logic                        d_ready;
    } tl_h2d_t;

    typedef struct packed {
        logic                        d_valid;
        logic [2:0]                  d_opcode;
        logic [top_pkg::TL_SZW-1:0]  d_size;
        logic [top_pkg::TL_AIW-1:0]  d_source;
        logic [top_pkg::TL_DW-1:0]   d_data;
        logic                        d_error;
        logic                        a_ready;
    } tl_d2h_t;
endpackage

// File: rtl/top_pkg.sv
// rtl/top_pkg.sv - TileLink-UL bus widths shared by the LLKI blocks
package top_pkg;
    localparam int TL_AW  = 32;
    localparam int TL_DW  = 64;
    localparam int TL_AIW = 8;
    localparam int TL_DBW = TL_DW / 8;
    localparam int TL_SZW = 2;
endpackage

// File: rtl/llki_tl_arb_fifo.sv
// rtl/llki_tl_arb_fifo.sv - order FIFO recording which host owns each outstanding A request
module llki_tl_arb_fifo
    import llki_pkg::*;
#(
    parameter int unsigned Depth = DEPTH_DEFAULT
) (
    input  logic                         i_clk,
    input  logic                         i_rst_n,
    input  logic                         i_push,
    input  logic                         i_pop,
    input  host_e                        i_data,
    output logic                         o_full,
    output logic                         o_empty,
    output host_e                        o_head,
    output logic [$clog2(Depth+1)-1:0]   o_count
);
    localparam int unsigned PW = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CW = $clog2(Depth + 1);

    host_e          r_mem [Depth];
    logic [PW-1:0]  r_wptr;
    logic [PW-1:0]  r_rptr;
    logic [CW-1:0]  r_count;
    logic           w_do_push;
    logic           w_do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(Depth - 1)) ? '0 : p + 1'b1;
    endfunction

    assign o_full    = (r_count == CW'(Depth));
    assign o_empty   = (r_count == '0);
    assign o_head    = r_mem[r_rptr];
    assign o_count   = r_count;
    assign w_do_push = i_push && !o_full;
    assign w_do_pop  = i_pop && !o_empty;

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
        end else begin
            if (w_do_push) begin
                r_mem[r_wptr] <= i_data;
                r_wptr        <= ptr_inc(r_wptr);
            end
            if (w_do_pop) r_rptr <= ptr_inc(r_rptr);
            if (w_do_push && !w_do_pop)      r_count <= r_count + 1'b1;
            else if (!w_do_push && w_do_pop) r_count <= r_count - 1'b1;
        end
    end
endmodule

// File: rtl/llki_tl_arb.sv
// rtl/llki_tl_arb.sv - two-host TL-UL arbiter onto one device, in-order D routing
// Optional: LLKI_TL_ARB_FIXED_PRIO_EN makes host 0 win every contention.
module llki_tl_arb
    import llki_pkg::*;
#(
    parameter int unsigned Depth     = DEPTH_DEFAULT,
    parameter int unsigned DataWidth = top_pkg::TL_DW
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    input  tlul_pkg::tl_h2d_t tl_h0_i,
    output tlul_pkg::tl_d2h_t tl_h0_o,
    input  tlul_pkg::tl_h2d_t tl_h1_i,
    output tlul_pkg::tl_d2h_t tl_h1_o,
    output tlul_pkg::tl_h2d_t tl_d_o,
    input  tlul_pkg::tl_d2h_t tl_d_i,
    output logic              busy_o,
    output logic              err_o
);
    localparam int unsigned CW = $clog2(Depth + 1);

    host_e              r_last;
    host_e              r_hold_host;
    logic               r_hold;
    logic               r_err;
    host_e              w_grant;
    host_e              w_head;
    tlul_pkg::tl_h2d_t  w_sel;
    logic               w_full;
    logic               w_empty;
    logic [CW-1:0]      w_count;
    logic               w_a_valid;
    logic               w_push;
    logic               w_pop;
    logic               w_head_d_ready;
    logic               w_route_valid;
    logic               w_hold_valid;

    assign w_hold_valid = (r_hold_host == HOST1) ? tl_h1_i.a_valid : tl_h0_i.a_valid;

    always_comb begin
        w_grant = HOST0;
        if (r_hold && w_hold_valid) begin
            w_grant = r_hold_host;
        end else begin
`ifdef LLKI_TL_ARB_FIXED_PRIO_EN
            w_grant = (!tl_h0_i.a_valid && tl_h1_i.a_valid) ? HOST1 : HOST0;
`else
            w_grant = rr_pick(tl_h0_i.a_valid, tl_h1_i.a_valid, r_last);
`endif
        end
    end

    assign w_sel          = (w_grant == HOST1) ? tl_h1_i : tl_h0_i;
    assign w_a_valid      = rst_ni && w_sel.a_valid && !w_full;
    assign w_push         = w_a_valid && tl_d_i.a_ready;
    assign w_head_d_ready = (w_head == HOST1) ? tl_h1_i.d_ready : tl_h0_i.d_ready;
    assign w_route_valid  = rst_ni && tl_d_i.d_valid && !w_empty;
    assign w_pop          = w_route_valid && w_head_d_ready;
    assign busy_o         = rst_ni && (w_count != '0);
    assign err_o          = r_err;

    // An empty FIFO means nobody owns the beat, so it is accepted and dropped.
    always_comb begin
        tl_d_o                          = w_sel;
        tl_d_o.a_valid                  = w_a_valid;
        tl_d_o.a_data                   = '0;
        tl_d_o.a_data[DataWidth-1:0]    = w_sel.a_data[DataWidth-1:0];
        tl_d_o.d_ready                  = w_empty ? 1'b1 : w_head_d_ready;

        tl_h0_o         = tl_d_i;
        tl_h0_o.d_valid = w_route_valid && (w_head == HOST0);
        tl_h0_o.a_ready = rst_ni && !w_full && tl_d_i.a_ready && (w_grant == HOST0);

        tl_h1_o         = tl_d_i;
        tl_h1_o.d_valid = w_route_valid && (w_head == HOST1);
        tl_h1_o.a_ready = rst_ni && !w_full && tl_d_i.a_ready && (w_grant == HOST1);
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_last      <= HOST1;
            r_hold      <= 1'b0;
            r_hold_host <= HOST0;
            r_err       <= 1'b0;
        end else begin
            if (w_push) r_last <= w_grant;
            r_hold      <= w_a_valid && !tl_d_i.a_ready;
            r_hold_host <= w_grant;
            if (tl_d_i.d_valid && w_empty) r_err <= 1'b1;
        end
    end

    llki_tl_arb_fifo #(
        .Depth (Depth)
    ) u_order_fifo (
        .i_clk   (clk_i),
        .i_rst_n (rst_ni),
        .i_push  (w_push),
        .i_pop   (w_pop),
        .i_data  (w_grant),
        .o_full  (w_full),
        .o_empty (w_empty),
        .o_head  (w_head),
        .o_count (w_count)
    );
endmodule

// File: doc/llki_tl_arb.md
LLKI_TL_ARB -- requirements
Module: llki_tl_arb

Interface
- REQ-001: Parameter Depth, default 4, sets maximum outstanding A-channel transactions; legal range 2..16.
- REQ-002: Parameter DataWidth, default top_pkg::TL_DW (64), sets TL-UL data width.
- REQ-003: Port clk_i, input, 1 bit, single clock; all logic is sampled on its rising edge.
- REQ-004: Port rst_ni, input, 1 bit; reset is synchronous and active-low.
- REQ-005: Port tl_h0_i, input, tlul_pkg::tl_h2d_t, host 0 request.
- REQ-006: Port tl_h0_o, output, tlul_pkg::tl_d2h_t, host 0 response.
- REQ-007: Port tl_h1_i, input, tlul_pkg::tl_h2d_t, host 1 request.
- REQ-008: Port tl_h1_o, output, tlul_pkg::tl_d2h_t, host 1 response.
- REQ-009: Port tl_d_o, output, tlul_pkg::tl_h2d_t, shared device request.
- REQ-010: Port tl_d_i, input, tlul_pkg::tl_d2h_t, shared device response.
- REQ-011: Port busy_o, output, 1 bit, high while any transaction is outstanding.
- REQ-012: Port err_o, output, 1 bit, sticky protocol-error flag.

Function
- REQ-013: The arbiter shall forward exactly one host A channel to tl_d_o per cycle; the A fields (opcode, address, source, size, mask, data) pass combinationally with zero added latency.
- REQ-014: Arbitration shall be round-robin; on a tie, the host not granted last wins.
- REQ-015: Once a granted host has a_valid high and device a_ready low, the grant shall hold until the handshake completes (no switch mid-stall).
- REQ-016: Each A handshake (tl_d_o.a_valid && tl_d_i.a_ready) shall push the granted host index into an order FIFO of Depth entries.
- REQ-017: When the FIFO count equals Depth, tl_d_o.a_valid shall be 0 and both host a_ready outputs 0; a same-cycle pop does not permit a push.
- REQ-018: D-channel responses shall be routed to the host at the FIFO head; the other host's d_valid shall be 0.
- REQ-019: A D handshake (routed d_valid && host d_ready) shall pop the FIFO; device d_ready shall equal the head host's d_ready.
- REQ-020: A push and a pop in the same cycle shall leave the count unchanged.
- REQ-021: tl_d_i.d_valid while the FIFO is empty shall set err_o, drive device d_ready=1 (drop the beat), and assert d_valid to neither host.
- REQ-022: Count and pointers shall wrap modulo Depth; count width shall be $clog2(Depth+1).
- REQ-023: busy_o shall equal (count != 0).

Reset
- REQ-024: When rst_ni=0 at a clock edge, the FIFO shall be emptied, count=0, the round-robin pointer set so host 0 wins the first tie, and err_o=0.
- REQ-025: During and immediately after reset, busy_o=0, all a_ready/d_valid outputs are 0, and tl_d_o.a_valid=0.
- REQ-026: Reset mid-operation shall discard outstanding order entries; late device responses shall then follow REQ-021.

Configuration
- REQ-027: Macro LLKI_TL_ARB_FIXED_PRIO_EN: when defined, host 0 always wins contention (REQ-015 still applies); when undefined, round-robin per REQ-014.

Structure
- REQ-028: Host-index typedef, Depth default, and arbiter constants belong in llki_pkg; TL widths come from top_pkg.
- REQ-029: The order FIFO shall be a sub-module named llki_tl_arb_fifo (push, pop, full, empty, head).

Verification
- REQ-030: Both hosts issue Get in the same cycle after reset, device ready -> host 0 granted first, host 1 the next cycle; responses return to h0 then h1.
- REQ-031: Host 0 issues 4 Gets with device d_valid held low (Depth=4) -> 5th request stalls with a_ready=0, busy_o=1; one response frees exactly one slot.
- REQ-032: Host 1 is granted with device a_ready=0 for 3 cycles while host 0 requests -> grant stays on host 1 until the handshake, then moves to host 0.
- REQ-033: Device drives d_valid with an empty FIFO -> err_o=1 next cycle and stays 1 until reset; neither host sees d_valid.
- REQ-034: Assert rst_ni=0 with 2 outstanding -> busy_o=0 after the edge; a later stray response sets err_o.
- REQ-035: With LLKI_TL_ARB_FIXED_PRIO_EN defined and both hosts continuously requesting -> host 0 receives every grant.
